gx_fifo_write_scheduler: RTL and testbench

- Sits between the CPU write-gather pipe and the 128-bit GX write-pipe AXI master.
- Packs 32-bit gather-pipe words into 32-byte lines using two ping-pong slots, and issues one 1- or 2-beat write request per line to the master.
- Owns the FIFO base/end/write pointer registers and advances the write pointer with wrap-around after each completed line.
- Latches AXI write errors reported by the master.

---
 rtl/gx_fifo_write_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_gx_fifo_write_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx_fifo_write_scheduler.sv
// gx_fifo_write_scheduler
// Gathers 32-bit CPU write-gather words into 32-byte lines held in two
// ping-pong slots, hands each finished line to the GX write-pipe AXI master
// as a one- or two-beat request, and maintains the FIFO base/end/write
// pointers plus a sticky copy of the first write error the master reports.

module gx_fifo_write_scheduler #(
   parameter logic [48:0] AXI_BASE = 49'h0,
   parameter int          PTR_W    = 26
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             gp_valid,
   input  logic [31:0]      gp_data,
   output logic             gp_ready,
   input  logic             gp_flush,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_sel,
   input  logic [31:0]      cfg_wdata,
   output logic [PTR_W-1:0] fifo_base,
   output logic [PTR_W-1:0] fifo_end,
   output logic [PTR_W-1:0] fifo_wptr,
   output logic             fifo_wrap,
   output logic             mst_write,
   input  logic             mst_next,
   output logic [127:0]     mst_data,
   output logic [48:0]      mst_addr,
   output logic             mst_size,
   input  logic             mst_ready,
   input  logic [1:0]       mst_berror,
   output logic [1:0]       err,
   output logic             idle
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   logic [31:0]      r_words [0:1][0:7];
   logic [3:0]       r_count [0:1];
   logic [1:0]       r_pending;
   logic             r_fill;
   logic             r_drain;
   logic             r_readyEn;

   state_t           r_state;
   state_t           w_nextState;

   logic [48:0]      r_addr;
   logic             r_size;
   logic [1:0]       r_nextCnt;

   logic [PTR_W-1:0] r_base;
   logic [PTR_W-1:0] r_end;
   logic [PTR_W-1:0] r_wptr;
   logic             r_wrap;
   logic [1:0]       r_err;

   logic             w_accept;
   logic [3:0]       w_fillCnt;
   logic [3:0]       w_newCnt;
   logic             w_goPend;
   logic             w_launch;
   logic             w_req;
   logic             w_done;
   logic             w_inXfer;
   logic [PTR_W-1:0] w_advAmt;
   logic [PTR_W-1:0] w_sum;
   logic             w_wrapHit;
   logic [127:0]     w_beat0;
   logic [127:0]     w_beat1;
   logic             w_cfgBase;
   logic             w_cfgEnd;
   logic             w_cfgWptr;
   logic             w_cfgClrErr;
   logic             w_unusedBits;

   assign w_unusedBits = ^{cfg_wdata[31:27], cfg_wdata[3:0]};

   assign gp_ready  = r_readyEn & ~r_pending[r_fill];
   assign w_accept  = gp_valid & gp_ready;
   assign w_fillCnt = r_count[r_fill];
   assign w_newCnt  = w_fillCnt + {3'b000, w_accept};
   assign w_goPend  = ~r_pending[r_fill] &
                      ((w_newCnt == 4'd8) | (gp_flush & (w_newCnt != 4'd0)));

   assign w_cfgBase   = cfg_we & (cfg_sel == 2'd0);
   assign w_cfgEnd    = cfg_we & (cfg_sel == 2'd1);
   assign w_cfgWptr   = cfg_we & (cfg_sel == 2'd2);
   assign w_cfgClrErr = cfg_we & (cfg_sel == 2'd3);

   assign w_beat0 = {r_words[r_drain][0], r_words[r_drain][1],
                     r_words[r_drain][2], r_words[r_drain][3]};
   assign w_beat1 = {r_words[r_drain][4], r_words[r_drain][5],
                     r_words[r_drain][6], r_words[r_drain][7]};

   assign w_advAmt  = r_size ? PTR_W'(32) : PTR_W'(16);
   assign w_sum     = r_wptr + w_advAmt;
   assign w_wrapHit = (r_wptr == r_end) | (~r_size & (w_sum == (r_end + PTR_W'(16))));

   assign mst_write = w_req;
   assign mst_addr  = r_addr;
   assign mst_size  = r_size;
   assign mst_data  = (r_nextCnt == 2'd2) ? w_beat1 : w_beat0;
   assign fifo_base = r_base;
   assign fifo_end  = r_end;
   assign fifo_wptr = r_wptr;
   assign fifo_wrap = r_wrap;
   assign err       = r_err;
   assign idle      = (r_count[0] == 4'd0) & (r_count[1] == 4'd0) & (r_state == S_IDLE);

   // Holds gp_ready low until the first clock after reset has been seen.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_readyEn <= 1'b0;
      end else begin
         r_readyEn <= 1'b1;
      end
   end

   // Slot storage: fill side writes words and closes lines, drain side frees the oldest line.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 8; w++) begin
               r_words[s][w] <= '0;
            end
            r_count[s] <= '0;
         end
         r_pending <= '0;
         r_fill    <= 1'b0;
         r_drain   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_words[r_fill][w_fillCnt[2:0]] <= gp_data;
            r_count[r_fill]                 <= w_newCnt;
         end
         if (w_goPend) begin
            r_pending[r_fill] <= 1'b1;
            r_fill            <= ~r_fill;
         end
         if (w_done) begin
            for (int w = 0; w < 8; w++) begin
               r_words[r_drain][w] <= '0;
            end
            r_count[r_drain]   <= '0;
            r_pending[r_drain] <= 1'b0;
            r_drain            <= ~r_drain;
         end
      end
   end

   // Drain FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Drain FSM next-state: launch when a line is ready, then follow the master's busy/idle handshake.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:      if (r_pending[r_drain] && mst_ready) w_nextState = S_REQ;
         S_REQ:       w_nextState = S_WAIT_BUSY;
         S_WAIT_BUSY: if (!mst_ready) w_nextState = S_WAIT_DONE;
         S_WAIT_DONE: if (mst_ready) w_nextState = S_IDLE;
         default:     w_nextState = S_IDLE;
      endcase
   end

   // Drain FSM outputs: request strobe, launch and completion events.
   always_comb begin
      w_launch = 1'b0;
      w_req    = 1'b0;
      w_done   = 1'b0;
      w_inXfer = 1'b0;
      case (r_state)
         S_IDLE:      w_launch = r_pending[r_drain] & mst_ready;
         S_REQ:       w_req    = 1'b1;
         S_WAIT_BUSY: w_inXfer = 1'b1;
         S_WAIT_DONE: begin
            w_inXfer = 1'b1;
            w_done   = mst_ready;
         end
         default: begin
            w_launch = 1'b0;
         end
      endcase
   end

   // Captures address and size at launch so they stay stable for the whole transfer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr <= '0;
         r_size <= 1'b0;
      end else if (w_launch) begin
         r_addr <= AXI_BASE + 49'(r_wptr);
         r_size <= (r_count[r_drain] > 4'd4);
      end
   end

   // Counts master word-advance pulses during a transfer to pick the beat on mst_data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_nextCnt <= '0;
      end else if (w_req) begin
         r_nextCnt <= '0;
      end else if (w_inXfer && mst_next && (r_nextCnt != 2'd2)) begin
         r_nextCnt <= r_nextCnt + 2'd1;
      end
   end

   // FIFO pointer registers: config writes, and the wrap-aware advance after each completed line.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_base <= '0;
         r_end  <= '0;
         r_wptr <= '0;
         r_wrap <= 1'b0;
      end else begin
         if (w_cfgBase) begin
            r_base <= {cfg_wdata[PTR_W-1:5], 5'b00000};
         end
         if (w_cfgEnd) begin
            r_end <= {cfg_wdata[PTR_W-1:5], 5'b00000};
         end
         if (w_cfgWptr) begin
            r_wptr <= {cfg_wdata[PTR_W-1:4], 4'b0000};
            r_wrap <= cfg_wdata[26];
         end else if (w_done) begin
            if (w_wrapHit) begin
               r_wptr <= r_base;
               r_wrap <= 1'b1;
            end else begin
               r_wptr <= w_sum;
            end
         end
      end
   end

   // Sticky error: keeps the first non-zero response until software clears it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_err <= '0;
      end else if (w_cfgClrErr) begin
         r_err <= '0;
      end else if (w_done && (r_err == 2'd0) && (mst_berror != 2'd0)) begin
         r_err <= mst_berror;
      end
   end

endmodule

// File: tb/tb_gx_fifo_write_scheduler.sv
// Testbench for gx_fifo_write_scheduler: config vector table, line pushes with
// a scoreboard of expected master requests, and a small AXI master model.

module tb_gx_fifo_write_scheduler;

   logic         clk = 1'b0;
   logic         resetn;
   logic         gp_valid;
   logic [31:0]  gp_data;
   logic         gp_ready;
   logic         gp_flush;
   logic         cfg_we;
   logic [1:0]   cfg_sel;
   logic [31:0]  cfg_wdata;
   logic [25:0]  fifo_base;
   logic [25:0]  fifo_end;
   logic [25:0]  fifo_wptr;
   logic         fifo_wrap;
   logic         mst_write;
   logic         mst_next;
   logic [127:0] mst_data;
   logic [48:0]  mst_addr;
   logic         mst_size;
   logic         mst_ready;
   logic [1:0]   mst_berror;
   logic [1:0]   err;
   logic         idle;

   typedef struct {
      logic [48:0]  addr;
      logic         size;
      logic [127:0] b0;
      logic [127:0] b1;
      logic [1:0]   berr;
   } req_t;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] wdata;
      logic [25:0] eBase;
      logic [25:0] eEnd;
      logic [25:0] eWptr;
      logic        eWrap;
   } cfg_vec_t;

   req_t        expQ[$];
   cfg_vec_t    cfgTable[5];
   int          tests = 0;
   int          fails = 0;
   int          reqCount = 0;
   bit          stallDone = 0;
   bit          modelStalled = 0;
   logic [25:0] mBase;
   logic [25:0] mEnd;
   logic [25:0] mWptr;
   logic        mWrap;

   gx_fifo_write_scheduler #(
      .AXI_BASE (49'h0),
      .PTR_W    (26)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .gp_valid   (gp_valid),
      .gp_data    (gp_data),
      .gp_ready   (gp_ready),
      .gp_flush   (gp_flush),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_wdata  (cfg_wdata),
      .fifo_base  (fifo_base),
      .fifo_end   (fifo_end),
      .fifo_wptr  (fifo_wptr),
      .fifo_wrap  (fifo_wrap),
      .mst_write  (mst_write),
      .mst_next   (mst_next),
      .mst_data   (mst_data),
      .mst_addr   (mst_addr),
      .mst_size   (mst_size),
      .mst_ready  (mst_ready),
      .mst_berror (mst_berror),
      .err        (err),
      .idle       (idle)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name, input string what);
      tests++;
      fails++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   task automatic cfgWrite(input logic [1:0] sel, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_sel   = sel;
      cfg_wdata = d;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   task automatic applyStimulus(input cfg_vec_t v, input int idx);
      cfgWrite(v.sel, v.wdata);
      checkOutput($sformatf("cfg%0d base", idx), 128'(fifo_base), 128'(v.eBase));
      checkOutput($sformatf("cfg%0d end", idx), 128'(fifo_end), 128'(v.eEnd));
      checkOutput($sformatf("cfg%0d wptr", idx), 128'(fifo_wptr), 128'(v.eWptr));
      checkOutput($sformatf("cfg%0d wrap", idx), 128'(fifo_wrap), 128'(v.eWrap));
   endtask

   task automatic pushWord(input logic [31:0] d, input logic fl);
      gp_valid = 1'b1;
      gp_data  = d;
      gp_flush = fl;
      for (int i = 0; i < 1000 && !gp_ready; i++) @(negedge clk);
      if (!gp_ready) failNow("push", "gp_ready never rose");
      @(negedge clk);
      gp_valid = 1'b0;
      gp_flush = 1'b0;
   endtask

   // flushMode: 0 = none, 1 = separate flush pulse, 2 = flush together with last word
   task automatic sendLine(input int n, input int flushMode, input logic [31:0] first, input logic [1:0] berr);
      logic [31:0] w [8];
      req_t        r;
      for (int i = 0; i < 8; i++) w[i] = (i < n) ? first + 32'(i) : 32'h0;
      r.addr = 49'(mWptr);
      r.size = (n > 4);
      r.b0   = {w[0], w[1], w[2], w[3]};
      r.b1   = {w[4], w[5], w[6], w[7]};
      r.berr = berr;
      expQ.push_back(r);
      if (mWptr == mEnd) begin
         mWptr = mBase;
         mWrap = 1'b1;
      end else begin
         mWptr = mWptr + (r.size ? 26'd32 : 26'd16);
      end
      for (int i = 0; i < n; i++) pushWord(w[i], (flushMode == 2) && (i == n - 1));
      if (flushMode == 1) begin
         gp_flush = 1'b1;
         @(negedge clk);
         gp_flush = 1'b0;
      end
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 1000 && !(expQ.size() == 0 && idle); i++) @(negedge clk);
      if (!(expQ.size() == 0 && idle))
         failNow(name, $sformatf("drain timeout, queue %0d idle %0b, required queue 0 idle 1", expQ.size(), idle));
   endtask

   // Master model: accepts each request, walks the beats with mst_next and returns a response.
   initial begin
      req_t r;
      mst_ready  = 1'b1;
      mst_next   = 1'b0;
      mst_berror = 2'd0;
      forever begin
         @(negedge clk);
         if (resetn && mst_write) begin
            reqCount++;
            if (expQ.size() == 0) begin
               failNow("req", "unexpected mst_write");
               r = '{addr: '0, size: 1'b0, b0: '0, b1: '0, berr: 2'd0};
            end else begin
               r = expQ.pop_front();
               checkOutput("req addr", 128'(mst_addr), 128'(r.addr));
               checkOutput("req size", 128'(mst_size), 128'(r.size));
            end
            mst_ready = 1'b0;
            @(negedge clk);
            checkOutput("beat0", mst_data, r.b0);
            mst_next = 1'b1;
            @(negedge clk);
            @(negedge clk);
            mst_next = 1'b0;
            checkOutput("beat1", mst_data, r.b1);
            modelStalled = 1'b1;
            for (int i = 0; i < 2000 && stallDone; i++) @(negedge clk);
            modelStalled = 1'b0;
            mst_berror = r.berr;
            mst_ready  = 1'b1;
         end
      end
   end

   // Watchdog so the run always ends with a summary.
   initial begin
      #2000000;
      failNow("watchdog", "simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Main test sequence.
   initial begin
      int n;
      resetn    = 1'b0;
      gp_valid  = 1'b0;
      gp_data   = '0;
      gp_flush  = 1'b0;
      cfg_we    = 1'b0;
      cfg_sel   = '0;
      cfg_wdata = '0;

      cfgTable[0] = '{sel: 2'd0, wdata: 32'h0000_101F, eBase: 26'h1000, eEnd: 26'h0,    eWptr: 26'h0,    eWrap: 1'b0};
      cfgTable[1] = '{sel: 2'd1, wdata: 32'h0000_1FFF, eBase: 26'h1000, eEnd: 26'h1FE0, eWptr: 26'h0,    eWrap: 1'b0};
      cfgTable[2] = '{sel: 2'd2, wdata: 32'h0400_1018, eBase: 26'h1000, eEnd: 26'h1FE0, eWptr: 26'h1010, eWrap: 1'b1};
      cfgTable[3] = '{sel: 2'd2, wdata: 32'h0000_1000, eBase: 26'h1000, eEnd: 26'h1FE0, eWptr: 26'h1000, eWrap: 1'b0};
      cfgTable[4] = '{sel: 2'd0, wdata: 32'hFC00_1010, eBase: 26'h1000, eEnd: 26'h1FE0, eWptr: 26'h1000, eWrap: 1'b0};

      repeat (2) @(negedge clk);
      checkOutput("rst mst_write", 128'(mst_write), 128'(0));
      checkOutput("rst gp_ready", 128'(gp_ready), 128'(0));
      checkOutput("rst wptr", 128'(fifo_wptr), 128'(0));
      checkOutput("rst err", 128'(err), 128'(0));
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("post-rst idle", 128'(idle), 128'(1));
      checkOutput("post-rst gp_ready", 128'(gp_ready), 128'(1));

      for (int i = 0; i < 5; i++) applyStimulus(cfgTable[i], i);
      mBase = 26'h1000;
      mEnd  = 26'h1FE0;
      mWptr = 26'h1000;
      mWrap = 1'b0;

      sendLine(8, 0, 32'h0000_0001, 2'd0);
      waitDrain("full line");
      checkOutput("full line wptr", 128'(fifo_wptr), 128'(26'h1020));

      sendLine(3, 1, 32'h0000_00A0, 2'd0);
      waitDrain("flush3");
      checkOutput("flush3 wptr", 128'(fifo_wptr), 128'(26'h1030));

      sendLine(5, 2, 32'h0000_00B0, 2'd0);
      waitDrain("flush5");
      checkOutput("flush5 wptr", 128'(fifo_wptr), 128'(26'h1050));

      n = reqCount;
      gp_flush = 1'b1;
      @(negedge clk);
      gp_flush = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("empty flush reqs", 128'(reqCount), 128'(n));
      checkOutput("empty flush idle", 128'(idle), 128'(1));
      checkOutput("empty flush wptr", 128'(fifo_wptr), 128'(26'h1050));

      cfgWrite(2'd2, 32'h0000_1FE0);
      mWptr = 26'h1FE0;
      sendLine(8, 0, 32'h0000_00C0, 2'd0);
      waitDrain("wrap");
      checkOutput("wrap wptr", 128'(fifo_wptr), 128'(26'h1000));
      checkOutput("wrap flag", 128'(fifo_wrap), 128'(1));
      cfgWrite(2'd2, 32'h0000_1000);
      mWrap = 1'b0;
      checkOutput("wrap clear", 128'(fifo_wrap), 128'(0));

      mst_ready = 1'b0;
      n = reqCount;
      sendLine(8, 0, 32'h0000_0100, 2'd0);
      sendLine(8, 0, 32'h0000_0200, 2'd0);
      checkOutput("both pending gp_ready", 128'(gp_ready), 128'(0));
      repeat (10) @(negedge clk);
      checkOutput("held reqs", 128'(reqCount), 128'(n));
      checkOutput("held gp_ready", 128'(gp_ready), 128'(0));
      mst_ready = 1'b1;
      waitDrain("release");
      checkOutput("release reqs", 128'(reqCount), 128'(n + 2));
      checkOutput("release gp_ready", 128'(gp_ready), 128'(1));
      checkOutput("release wptr", 128'(fifo_wptr), 128'(26'h1040));

      sendLine(8, 0, 32'h0000_0300, 2'd2);
      waitDrain("err first");
      checkOutput("err first", 128'(err), 128'(2));
      sendLine(4, 1, 32'h0000_0400, 2'd3);
      waitDrain("err sticky");
      checkOutput("err sticky", 128'(err), 128'(2));
      cfgWrite(2'd3, 32'h0);
      checkOutput("err clear", 128'(err), 128'(0));
      sendLine(2, 1, 32'h0000_0500, 2'd1);
      waitDrain("err recapture");
      checkOutput("err recapture", 128'(err), 128'(1));
      checkOutput("err wptr", 128'(fifo_wptr), 128'(26'h1080));

      stallDone = 1'b1;
      sendLine(8, 0, 32'h0000_0600, 2'd0);
      for (int i = 0; i < 1000 && !modelStalled; i++) @(negedge clk);
      if (!modelStalled) failNow("reset stall", "master model never reached completion point");
      resetn = 1'b0;
      #1;
      checkOutput("in-rst mst_write", 128'(mst_write), 128'(0));
      checkOutput("in-rst gp_ready", 128'(gp_ready), 128'(0));
      @(negedge clk);
      resetn = 1'b1;
      #1;
      checkOutput("rel mst_write", 128'(mst_write), 128'(0));
      checkOutput("rel gp_ready", 128'(gp_ready), 128'(0));
      checkOutput("rel idle", 128'(idle), 128'(1));
      checkOutput("rel base", 128'(fifo_base), 128'(0));
      checkOutput("rel end", 128'(fifo_end), 128'(0));
      checkOutput("rel wptr", 128'(fifo_wptr), 128'(0));
      checkOutput("rel err", 128'(err), 128'(0));
      stallDone = 1'b0;
      mBase = 26'h0;
      mEnd  = 26'h0;
      mWptr = 26'h0;
      mWrap = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("recover gp_ready", 128'(gp_ready), 128'(1));
      sendLine(8, 0, 32'h0000_0700, 2'd0);
      waitDrain("recover");
      checkOutput("recover wptr", 128'(fifo_wptr), 128'(mWptr));
      checkOutput("recover wrap", 128'(fifo_wrap), 128'(mWrap));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
